// File: rtl/fp_exc_pkg.sv
// Shared types and constant builders for the FPU special-operand classifier.
package fp_exc_pkg;

    typedef enum logic [2:0] {
        FLAG_NONE       = 3'b000,
        FLAG_NAN        = 3'b001,
        FLAG_COPY_A     = 3'b010,
        FLAG_COPY_B     = 3'b011,
        FLAG_INF        = 3'b100,
        FLAG_ZERO       = 3'b101,
        FLAG_COPY_NEG_B = 3'b110,
        FLAG_CANCEL     = 3'b111
    } flag_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef struct packed {
        logic sign;
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
    } op_class_t;

    // Built in 64 bits; callers keep the low 1+EXP_BITS+MANT_BITS bits.
    function automatic logic [63:0] can_nan_bits(input int exp_bits, input int mant_bits);
        logic [63:0] r;
        r = ((64'd1 << exp_bits) - 64'd1) << mant_bits;
        r = r | (64'd1 << (mant_bits - 1));
        return r;
    endfunction

    function automatic logic [63:0] inf_bits(input int exp_bits, input int mant_bits);
        return ((64'd1 << exp_bits) - 64'd1) << mant_bits;
    endfunction

endpackage

// File: rtl/fp_exception_pipe_classify.sv
// Combinational IEEE-754 operand decode; denormals count as finite nonzero.
module fp_operand_classify
    import fp_exc_pkg::*;
#(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int WIDTH     = 1 + EXP_BITS + MANT_BITS
) (
    input  logic [WIDTH-1:0] x,
    output op_class_t        cls
);

    logic [EXP_BITS-1:0]  exp_f;
    logic [MANT_BITS-1:0] mant_f;
    logic                 exp_ones;
    logic                 exp_zero;
    logic                 mant_zero;

    assign exp_f     = x[WIDTH-2:MANT_BITS];
    assign mant_f    = x[MANT_BITS-1:0];
    assign exp_ones  = &exp_f;
    assign exp_zero  = (exp_f == '0);
    assign mant_zero = (mant_f == '0);

    always_comb begin
        cls.sign    = x[WIDTH-1];
        cls.is_zero = exp_zero && mant_zero;
        cls.is_inf  = exp_ones && mant_zero;
        cls.is_nan  = exp_ones && !mant_zero;
        cls.is_snan = exp_ones && !mant_zero && !mant_f[MANT_BITS-1];
    end

endmodule

// File: rtl/fp_exception_pipe.sv
// Two-stage special-operand classifier in front of the FPU add/sub/mul core,
// producing an exception code, a substitute result and sticky IEEE status.
module fp_exception_pipe
    import fp_exc_pkg::*;
#(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int WIDTH     = 1 + EXP_BITS + MANT_BITS
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output flag_e            exception_flag,
    output logic [WIDTH-1:0] special_result,
    output logic             invalid_sticky,
    output logic             nan_in_sticky,
    input  logic             clear_sticky
);

    if (WIDTH != 1 + EXP_BITS + MANT_BITS) begin : g_width_check
        $error("fp_exception_pipe: WIDTH must equal 1+EXP_BITS+MANT_BITS");
    end

    localparam logic [63:0]      CAN_NAN_64 = can_nan_bits(EXP_BITS, MANT_BITS);
    localparam logic [63:0]      INF_64     = inf_bits(EXP_BITS, MANT_BITS);
    localparam logic [WIDTH-1:0] CAN_NAN    = CAN_NAN_64[WIDTH-1:0];
    localparam logic [WIDTH-2:0] INF_MAG    = INF_64[WIDTH-2:0];

    op_class_t cls_a;
    op_class_t cls_b;

    fp_operand_classify #(.EXP_BITS(EXP_BITS), .MANT_BITS(MANT_BITS), .WIDTH(WIDTH))
        u_cls_a (.x(a), .cls(cls_a));
    fp_operand_classify #(.EXP_BITS(EXP_BITS), .MANT_BITS(MANT_BITS), .WIDTH(WIDTH))
        u_cls_b (.x(b), .cls(cls_b));

    logic advance;
    logic out_hs;

    logic             vld1_q;
    op_e              op_q;
    op_class_t        cls_a_q;
    op_class_t        cls_b_q;
    logic             eb_q;
    logic             mag_eq_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-2:0] b_mag_q;

    logic             vld2_q;
    flag_e            flag_q;
    logic [WIDTH-1:0] res_q;
    logic             inv2_q;
    logic             nan2_q;
    logic             inv_st_q;
    logic             nan_st_q;

    flag_e            flag_d;
    logic [WIDTH-1:0] res_d;
    logic             inv_d;
    logic             nan_d;
    logic             inv_st_d;
    logic             nan_st_d;

    assign advance  = !vld2_q || out_ready;
    assign in_ready = advance;
    assign out_hs   = vld2_q && out_ready;

    // Stage 1: per-operand decode
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld1_q   <= 1'b0;
            op_q     <= OP_ADD;
            cls_a_q  <= '0;
            cls_b_q  <= '0;
            eb_q     <= 1'b0;
            mag_eq_q <= 1'b0;
            a_q      <= '0;
            b_mag_q  <= '0;
        end else if (advance) begin
            vld1_q <= in_valid;
            if (in_valid) begin
                op_q     <= op_e'(op);
                cls_a_q  <= cls_a;
                cls_b_q  <= cls_b;
                eb_q     <= b[WIDTH-1] ^ (op == OP_SUB);
                mag_eq_q <= (a[WIDTH-2:0] == b[WIDTH-2:0]);
                a_q      <= a;
                b_mag_q  <= b[WIDTH-2:0];
            end
        end
    end

    always_comb begin
        flag_d = FLAG_NONE;
        res_d  = '0;
        inv_d  = cls_a_q.is_snan || cls_b_q.is_snan;
        nan_d  = cls_a_q.is_nan || cls_b_q.is_nan;
        case (op_q)
            OP_ADD, OP_SUB: begin
                if (cls_a_q.is_nan || cls_b_q.is_nan) begin
                    flag_d = FLAG_NAN;
                    res_d  = CAN_NAN;
                end else if (cls_a_q.is_inf && cls_b_q.is_inf && (cls_a_q.sign != eb_q)) begin
                    flag_d = FLAG_NAN;
                    res_d  = CAN_NAN;
                    inv_d  = 1'b1;
                end else if (cls_a_q.is_inf) begin
                    flag_d = FLAG_INF;
                    res_d  = {cls_a_q.sign, INF_MAG};
                end else if (cls_b_q.is_inf) begin
                    flag_d = FLAG_INF;
                    res_d  = {eb_q, INF_MAG};
                end else if (cls_a_q.is_zero && cls_b_q.is_zero) begin
                    flag_d = FLAG_ZERO;
                    res_d  = {cls_a_q.sign & eb_q, {(WIDTH-1){1'b0}}};
                end else if (cls_a_q.is_zero) begin
                    flag_d = (op_q == OP_SUB) ? FLAG_COPY_NEG_B : FLAG_COPY_B;
                    res_d  = {eb_q, b_mag_q};
                end else if (cls_b_q.is_zero) begin
                    flag_d = FLAG_COPY_A;
                    res_d  = a_q;
                end else if (mag_eq_q && (cls_a_q.sign != eb_q)) begin
                    flag_d = FLAG_CANCEL;
                end
            end
            OP_MUL: begin
                if (cls_a_q.is_nan || cls_b_q.is_nan) begin
                    flag_d = FLAG_NAN;
                    res_d  = CAN_NAN;
                end else if ((cls_a_q.is_inf && cls_b_q.is_zero) ||
                             (cls_a_q.is_zero && cls_b_q.is_inf)) begin
                    flag_d = FLAG_NAN;
                    res_d  = CAN_NAN;
                    inv_d  = 1'b1;
                end else if (cls_a_q.is_inf || cls_b_q.is_inf) begin
                    flag_d = FLAG_INF;
                    res_d  = {cls_a_q.sign ^ cls_b_q.sign, INF_MAG};
                end else if (cls_a_q.is_zero || cls_b_q.is_zero) begin
                    flag_d = FLAG_ZERO;
                    res_d  = {cls_a_q.sign ^ cls_b_q.sign, {(WIDTH-1){1'b0}}};
                end
            end
            default: begin
                flag_d = FLAG_NAN;
                res_d  = CAN_NAN;
                inv_d  = 1'b1;
            end
        endcase
    end

    // Set beats a simultaneous clear so an exception retiring this cycle is never lost.
    assign inv_st_d = (inv_st_q && !clear_sticky) || (out_hs && inv2_q);
    assign nan_st_d = (nan_st_q && !clear_sticky) || (out_hs && nan2_q);

    // Stage 2: exception resolution and sticky status
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld2_q   <= 1'b0;
            flag_q   <= FLAG_NONE;
            res_q    <= '0;
            inv2_q   <= 1'b0;
            nan2_q   <= 1'b0;
            inv_st_q <= 1'b0;
            nan_st_q <= 1'b0;
        end else begin
            inv_st_q <= inv_st_d;
            nan_st_q <= nan_st_d;
            if (advance) begin
                vld2_q <= vld1_q;
                if (vld1_q) begin
                    flag_q <= flag_d;
                    res_q  <= res_d;
                    inv2_q <= inv_d;
                    nan2_q <= nan_d;
                end
            end
        end
    end

    assign out_valid      = vld2_q;
    assign exception_flag = flag_q;
    assign special_result = res_q;
    assign invalid_sticky = inv_st_q;
    assign nan_in_sticky  = nan_st_q;

endmodule

// File: tb/tb_fp_exception_pipe.sv
// Directed-vector bench for fp_exception_pipe (single precision).
module tb_fp_exception_pipe;
    import fp_exc_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    flag_e       exception_flag;
    logic [31:0] special_result;
    logic        invalid_sticky;
    logic        nan_in_sticky;
    logic        clear_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    fp_exception_pipe #(.EXP_BITS(8), .MANT_BITS(23), .WIDTH(32)) dut (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .exception_flag(exception_flag), .special_result(special_result),
        .invalid_sticky(invalid_sticky), .nan_in_sticky(nan_in_sticky),
        .clear_sticky(clear_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] ef, input logic [31:0] er, input string nm);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++; $display("FAIL %s valid: got %0b want 1", nm, out_valid);
        end
        n_cmp++;
        if (exception_flag !== ef) begin
            n_bad++; $display("FAIL %s flag: got %03b want %03b", nm, exception_flag, ef);
        end
        n_cmp++;
        if (special_result !== er) begin
            n_bad++; $display("FAIL %s result: got %08h want %08h", nm, special_result, er);
        end
        tick();
    endtask

    task automatic check_sticky(input logic ei, input logic en, input string nm);
        n_cmp++;
        if (invalid_sticky !== ei) begin
            n_bad++; $display("FAIL %s invalid_sticky: got %0b want %0b", nm, invalid_sticky, ei);
        end
        n_cmp++;
        if (nan_in_sticky !== en) begin
            n_bad++; $display("FAIL %s nan_in_sticky: got %0b want %0b", nm, nan_in_sticky, en);
        end
    endtask

    task automatic pulse_clear();
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        #13;
        n_cmp++;
        if (out_valid !== 1'b0 || exception_flag !== 3'b000 || special_result !== 32'h0) begin
            n_bad++;
            $display("FAIL reset outputs: got v=%0b f=%03b r=%08h want 0/000/00000000",
                     out_valid, exception_flag, special_result);
        end
        check_sticky(1'b0, 1'b0, "reset");
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset in_ready: got %0b want 1", in_ready);
        end
        @(negedge clk);
        arst_n = 1'b1;
        tick();
    endtask

    task automatic test_nan_add();
        run_op(2'b00, 32'h7FC00001, 32'h3F800000, 3'b001, 32'h7FC00000, "qnan_add");
        check_sticky(1'b0, 1'b1, "qnan_add");
        pulse_clear();
        check_sticky(1'b0, 1'b0, "clear_after_qnan");
    endtask

    task automatic test_inf_sub();
        run_op(2'b01, 32'h7F800000, 32'h7F800000, 3'b001, 32'h7FC00000, "inf_minus_inf");
        check_sticky(1'b1, 1'b0, "inf_minus_inf");
        pulse_clear();
        check_sticky(1'b0, 1'b0, "clear_after_inf");
    endtask

    task automatic test_copy();
        run_op(2'b01, 32'h00000000, 32'h40400000, 3'b110, 32'hC0400000, "zero_sub_b");
        run_op(2'b00, 32'h40400000, 32'h80000000, 3'b010, 32'h40400000, "a_add_negzero");
        run_op(2'b00, 32'h80000000, 32'h40400000, 3'b011, 32'h40400000, "negzero_add_b");
        check_sticky(1'b0, 1'b0, "copy");
    endtask

    task automatic test_cancel_zero();
        run_op(2'b01, 32'h3FC00000, 32'h3FC00000, 3'b111, 32'h00000000, "cancel");
        run_op(2'b00, 32'h80000000, 32'h80000000, 3'b101, 32'h80000000, "negzero_sum");
        run_op(2'b01, 32'h80000000, 32'h80000000, 3'b101, 32'h00000000, "negzero_diff");
        run_op(2'b00, 32'h3FC00000, 32'h3FC00000, 3'b000, 32'h00000000, "plain_add");
    endtask

    task automatic test_mul();
        run_op(2'b10, 32'h7F800000, 32'h80000000, 3'b001, 32'h7FC00000, "inf_mul_zero");
        check_sticky(1'b1, 1'b0, "inf_mul_zero");
        run_op(2'b10, 32'hFF800000, 32'h40000000, 3'b100, 32'hFF800000, "neginf_mul");
        run_op(2'b10, 32'h80000000, 32'h40000000, 3'b101, 32'h80000000, "negzero_mul");
        run_op(2'b10, 32'h00000001, 32'h40400000, 3'b000, 32'h00000000, "denorm_mul");
        pulse_clear();
        check_sticky(1'b0, 1'b0, "clear_after_mul");
    endtask

    task automatic test_snan_reserved();
        run_op(2'b00, 32'h3F800000, 32'h7F800001, 3'b001, 32'h7FC00000, "snan_add");
        check_sticky(1'b1, 1'b1, "snan_add");
        pulse_clear();
        run_op(2'b11, 32'h3F800000, 32'h3F800000, 3'b001, 32'h7FC00000, "reserved_op");
        check_sticky(1'b1, 1'b0, "reserved_op");
        pulse_clear();
        check_sticky(1'b0, 1'b0, "clear_after_rsvd");
    endtask

    task automatic test_set_wins();
        op = 2'b11; a = 32'h0; b = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        check_sticky(1'b1, 1'b0, "set_beats_clear");
        pulse_clear();
        check_sticky(1'b0, 1'b0, "clear_after_set_wins");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  po[4];
        logic [31:0] pa[4];
        logic [31:0] pb[4];
        logic [2:0]  ef[4];
        logic [31:0] er[4];
        logic [2:0]  gf[4];
        logic [31:0] gr[4];
        int          idx;
        int          n;
        logic        held;
        logic [2:0]  hf;
        logic [31:0] hr;
        po = '{2'b00, 2'b10, 2'b00, 2'b01};
        pa = '{32'h7F800000, 32'h00000000, 32'h3F800000, 32'h3F800000};
        pb = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h00000000};
        ef = '{3'b100, 3'b101, 3'b000, 3'b010};
        er = '{32'h7F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
        gf = '{default: 3'b000};
        gr = '{default: 32'h0};
        idx = 0; n = 0; held = 1'b0; hf = 3'b000; hr = 32'h0;
        for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            #1;
            if (out_valid && !out_ready) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++; $display("FAIL b2b in_ready_stall: got %0b want 0", in_ready);
                end
                if (held) begin
                    n_cmp++;
                    if (exception_flag !== hf || special_result !== hr) begin
                        n_bad++;
                        $display("FAIL b2b hold: got %03b/%08h want %03b/%08h",
                                 exception_flag, special_result, hf, hr);
                    end
                end
                held = 1'b1; hf = exception_flag; hr = special_result;
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (n < 4) begin
                    gf[n] = exception_flag; gr[n] = special_result;
                end
                n++;
            end
            if (idx < 4) begin
                in_valid = 1'b1; op = po[idx]; a = pa[idx]; b = pb[idx];
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (n !== 4) begin
            n_bad++; $display("FAIL b2b count: got %0d want 4", n);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b extra_output: got valid %0b want 0", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (gf[i] !== ef[i] || gr[i] !== er[i]) begin
                n_bad++;
                $display("FAIL b2b item%0d: got %03b/%08h want %03b/%08h", i, gf[i], gr[i], ef[i], er[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        run_op(2'b00, 32'h7FC00000, 32'h7F800001, 3'b001, 32'h7FC00000, "pre_reset_nan");
        check_sticky(1'b1, 1'b1, "pre_reset_nan");
        out_ready = 1'b0;
        op = 2'b00; a = 32'h7FC00000; b = 32'h0; in_valid = 1'b1;
        tick();
        a = 32'h7F800000;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || exception_flag !== 3'b001) begin
            n_bad++; $display("FAIL mid_reset pre: got v=%0b f=%03b want 1/001", out_valid, exception_flag);
        end
        arst_n = 1'b0;
        #2;
        arst_n = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || exception_flag !== 3'b000 || special_result !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset outputs: got v=%0b f=%03b r=%08h want 0/000/00000000",
                     out_valid, exception_flag, special_result);
        end
        check_sticky(1'b0, 1'b0, "mid_reset");
        out_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset discard: got valid %0b want 0", out_valid);
        end
        check_sticky(1'b0, 1'b0, "post_reset");
    endtask

    initial begin
        in_valid = 1'b0; a = '0; b = '0; op = 2'b00;
        out_ready = 1'b1; clear_sticky = 1'b0; arst_n = 1'b1;
        test_reset();
        test_nan_add();
        test_inf_sub();
        test_copy();
        test_cancel_zero();
        test_mul();
        test_snan_reserved();
        test_set_wins();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
